// File: rtl/t01_ai_pkg.sv
// t01_ai_pkg: piece, state and shape types plus the rotation ROM for the placement streamer.
// Patterns are 16-bit literals with one hex digit per row, top row first;
// the MSB of each digit is column 0.
package t01_ai_pkg;

    typedef enum logic [2:0] {
        PC_I, PC_O, PC_S, PC_Z, PC_J, PC_L, PC_T, PC_NONE
    } piece_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SPAWN, ST_DROP, ST_EMIT, ST_NEXT, ST_FINISH
    } state_t;

    // pat[r][3-c] set means cell (r,c) is occupied
    typedef struct packed {
        logic [3:0][3:0] pat;
        logic [2:0]      w;
        logic [2:0]      h;
    } shape_t;

    function automatic shape_t mk(logic [15:0] rows, logic [2:0] w, logic [2:0] h);
        return '{pat: {rows[3:0], rows[7:4], rows[11:8], rows[15:12]}, w: w, h: h};
    endfunction

    function automatic shape_t get_pattern(piece_t p, logic [1:0] rot);
        case ({p, rot})
            {PC_I, 2'd0}: return mk(16'h8888, 3'd1, 3'd4);
            {PC_I, 2'd1}: return mk(16'hF000, 3'd4, 3'd1);
            {PC_O, 2'd0}: return mk(16'hCC00, 3'd2, 3'd2);
            {PC_S, 2'd0}: return mk(16'h6C00, 3'd3, 3'd2);
            {PC_S, 2'd1}: return mk(16'h8C40, 3'd2, 3'd3);
            {PC_Z, 2'd0}: return mk(16'hC600, 3'd3, 3'd2);
            {PC_Z, 2'd1}: return mk(16'h4C80, 3'd2, 3'd3);
            {PC_J, 2'd0}: return mk(16'h8E00, 3'd3, 3'd2);
            {PC_J, 2'd1}: return mk(16'hC880, 3'd2, 3'd3);
            {PC_J, 2'd2}: return mk(16'hE200, 3'd3, 3'd2);
            {PC_J, 2'd3}: return mk(16'h44C0, 3'd2, 3'd3);
            {PC_L, 2'd0}: return mk(16'h2E00, 3'd3, 3'd2);
            {PC_L, 2'd1}: return mk(16'h88C0, 3'd2, 3'd3);
            {PC_L, 2'd2}: return mk(16'hE800, 3'd3, 3'd2);
            {PC_L, 2'd3}: return mk(16'hC440, 3'd2, 3'd3);
            {PC_T, 2'd0}: return mk(16'h4E00, 3'd3, 3'd2);
            {PC_T, 2'd1}: return mk(16'h8C80, 3'd2, 3'd3);
            {PC_T, 2'd2}: return mk(16'hE400, 3'd3, 3'd2);
            {PC_T, 2'd3}: return mk(16'h4C40, 3'd2, 3'd3);
            default:      return mk(16'h0000, 3'd0, 3'd0);
        endcase
    endfunction

    function automatic logic [1:0] max_rot(piece_t p);
        return (p == PC_O || p == PC_NONE) ? 2'd0 :
               (p == PC_I || p == PC_S || p == PC_Z) ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/t01_ai_piece_mask.sv
// t01_ai_piece_mask: places a 4x4 pattern at (x,row) on the board and flags overlap.
// Ports: pat (4x4 pattern), x (left column), row (top row), board (occupancy),
//        mask (placed piece cells), hit (mask overlaps board).
module t01_ai_piece_mask #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW = $clog2(BOARD_W),
    parameter int YW = $clog2(BOARD_H)
) (
    input  logic [3:0][3:0]              pat,
    input  logic [XW-1:0]                x,
    input  logic [YW-1:0]                row,
    input  logic [BOARD_W*BOARD_H-1:0]   board,
    output logic [BOARD_W*BOARD_H-1:0]   mask,
    output logic                         hit
);
    // Each board cell looks back into the pattern; a negative offset wraps to a
    // value with upper bits set, so one zero test covers both "above" and "beyond".
    for (genvar r = 0; r < BOARD_H; r++) begin : g_row
        logic [YW:0] dr;
        assign dr = (YW+1)'(r) - {1'b0, row};
        for (genvar c = 0; c < BOARD_W; c++) begin : g_col
            logic [XW:0] dc;
            assign dc = (XW+1)'(c) - {1'b0, x};
            assign mask[r*BOARD_W+c] = dr[YW:2] == '0 && dc[XW:2] == '0 && pat[dr[1:0]][~dc[1:0]];
        end
    end
    assign hit = |(mask & board);
endmodule

// File: rtl/t01_ai_placement_streamer.sv
// t01_ai_placement_streamer: enumerates every rotation/column drop of a piece and streams candidates.
// Ports: clk, reset (async, active-high), start/abort (control), board_in/piece_type (snapshot),
//        busy, cand_valid/cand_ready (candidate handshake), cand_rot/cand_x/cand_row/cand_board
//        (payload), done (end pulse), cand_count (candidates emitted this run).
module t01_ai_placement_streamer
    import t01_ai_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    localparam int XW = $clog2(BOARD_W),
    localparam int YW = $clog2(BOARD_H),
    localparam int CW = $clog2(4*BOARD_W+1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [BOARD_W*BOARD_H-1:0]   board_in,
    input  logic [2:0]                   piece_type,
    output logic                         busy,
    output logic                         cand_valid,
    input  logic                         cand_ready,
    output logic [1:0]                   cand_rot,
    output logic [XW-1:0]                cand_x,
    output logic [YW-1:0]                cand_row,
    output logic [BOARD_W*BOARD_H-1:0]   cand_board,
    output logic                         done,
    output logic [CW-1:0]                cand_count
);
    localparam int N = BOARD_W * BOARD_H;

    state_t         state, nxt;
    piece_t         piece_q;
    shape_t         shape;
    logic [N-1:0]   board_q, cand_q, mask;
    logic [1:0]     rot;
    logic [XW-1:0]  x;
    logic [YW-1:0]  row, test_row;
    logic [CW-1:0]  count;
    logic           hit, land, x_more, rot_more;

    // SPAWN probes row 0, DROP probes the row below the current one
    assign test_row = (state == ST_DROP) ? row + 1'b1 : '0;
    assign land     = (int'(row) + 1 + int'(shape.h) > BOARD_H) || hit;
    assign x_more   = int'(x) < BOARD_W - int'(shape.w);
    assign rot_more = rot < max_rot(piece_q);

    t01_ai_piece_mask #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .XW(XW), .YW(YW)) u_mask (
        .pat   (shape.pat),
        .x     (x),
        .row   (test_row),
        .board (board_q),
        .mask  (mask),
        .hit   (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   nxt = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:   nxt = (piece_q == PC_NONE) ? ST_FINISH : ST_SPAWN;
            ST_SPAWN:  nxt = hit ? ST_NEXT : ST_DROP;
            ST_DROP:   nxt = land ? ST_EMIT : ST_DROP;
            ST_EMIT:   nxt = cand_ready ? ST_NEXT : ST_EMIT;
            ST_NEXT:   nxt = x_more ? ST_SPAWN : rot_more ? ST_LOAD : ST_FINISH;
            default:   nxt = ST_IDLE;
        endcase
        if (abort) nxt = ST_IDLE;
    end

    always_comb begin
        busy       = state != ST_IDLE;
        cand_valid = state == ST_EMIT;
        done       = state == ST_FINISH;
    end

    // cand_q always holds board_q merged with the piece at the current row, so
    // it is already the payload when DROP lands and stays frozen through EMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            piece_q <= PC_I;
            shape   <= '0;
            board_q <= '0;
            cand_q  <= '0;
            rot     <= '0;
            x       <= '0;
            row     <= '0;
            count   <= '0;
        end else if (!abort) begin
            case (state)
                ST_IDLE: if (start) begin
                    board_q <= board_in;
                    piece_q <= piece_t'(piece_type);
                    rot     <= '0;
                    x       <= '0;
                    count   <= '0;
                end
                ST_LOAD: begin
                    shape <= get_pattern(piece_q, rot);
                    x     <= '0;
                end
                ST_SPAWN: begin
                    row <= '0;
                    if (!hit) cand_q <= board_q | mask;
                end
                ST_DROP: if (!land) begin
                    row    <= row + 1'b1;
                    cand_q <= board_q | mask;
                end
                ST_EMIT: if (cand_ready) count <= count + 1'b1;
                ST_NEXT: begin
                    if (x_more)        x   <= x + 1'b1;
                    else if (rot_more) rot <= rot + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cand_rot   = rot;
    assign cand_x     = x;
    assign cand_row   = row;
    assign cand_board = cand_q;
    assign cand_count = count;
endmodule

// File: tb/tb_t01_ai_placement_streamer.sv
// tb_t01_ai_placement_streamer: scoreboard bench for the placement streamer.
module tb_t01_ai_placement_streamer;
    localparam int W  = 10;
    localparam int H  = 20;
    localparam int N  = W * H;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int CW = $clog2(4*W+1);

    logic          clk = 0, reset = 1, start = 0, abort = 0, cand_ready = 0;
    logic [N-1:0]  board_in = '0;
    logic [2:0]    piece_type = '0;
    logic          busy, cand_valid, done;
    logic [1:0]    cand_rot;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_row;
    logic [N-1:0]  cand_board;
    logic [CW-1:0] cand_count;

    typedef struct {
        logic [1:0]   rot;
        int           x;
        int           row;
        logic [N-1:0] board;
        bit           exact;
    } exp_t;

    exp_t sb[$];
    int tests = 0, fails = 0, n_done = 0;

    t01_ai_placement_streamer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .board_in(board_in), .piece_type(piece_type), .busy(busy),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_rot(cand_rot),
        .cand_x(cand_x), .cand_row(cand_row), .cand_board(cand_board),
        .done(done), .cand_count(cand_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_board(string name, logic [N-1:0] act, logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Filled rectangle; O and I shapes are exactly their bounding box.
    function automatic logic [N-1:0] box(int x, int row, int w, int h);
        logic [N-1:0] b = '0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                b[(row+r)*W + x + c] = 1'b1;
        return b;
    endfunction

    // Empty board: every column 0..W-w lands with its bottom on row H-1.
    task automatic push_rot(logic [1:0] rot, int w, int h, bit exact);
        for (int x = 0; x <= W - w; x++)
            sb.push_back('{rot, x, H - h, box(x, H - h, w, h), exact});
    endtask

    task automatic go(logic [2:0] p, logic [N-1:0] b);
        @(posedge clk);
        #1 board_in = b; piece_type = p; start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(string name, int exp_cnt);
        bit seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check({name, "_done"}, 64'(seen), 1);
        if (seen) check({name, "_count"}, 64'(cand_count), 64'(exp_cnt));
        check({name, "_sb_left"}, 64'(sb.size()), 0);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 0);
    endtask

    task automatic wait_valid(string name);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = cand_valid;
        end
        check(name, 64'(seen), 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) n_done++;
        if (!reset && cand_valid && cand_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_cand: got rot %0d x %0d row %0d, required none", cand_rot, cand_x, cand_row);
            end else begin
                e = sb.pop_front();
                check("cand_rot", 64'(cand_rot), 64'(e.rot));
                check("cand_x", 64'(cand_x), 64'(e.x));
                check("cand_row", 64'(cand_row), 64'(e.row));
                if (e.exact) check_board("cand_board", cand_board, e.board);
                else begin
                    check("cand_bits", 64'($countones(cand_board)), 4);
                    check("cand_bits_in_box", 64'($countones(cand_board & e.board)), 4);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] top2;
        int d0;
        top2 = '0;
        top2[2*W-1:0] = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_valid", 64'(cand_valid), 0);
        check("rst_done", 64'(done), 0);
        check("rst_count", 64'(cand_count), 0);
        check_board("rst_board", cand_board, '0);
        @(posedge clk);
        #1 reset = 0; cand_ready = 1;

        push_rot(0, 2, 2, 1);
        go(3'd1, '0);
        wait_done("o_empty", 9);

        push_rot(0, 1, 4, 1);
        push_rot(1, 4, 1, 1);
        go(3'd0, '0);
        wait_done("i_empty", 17);

        push_rot(0, 3, 2, 0);
        push_rot(1, 2, 3, 0);
        push_rot(2, 3, 2, 0);
        push_rot(3, 2, 3, 0);
        go(3'd6, '0);
        wait_done("t_empty", 34);

        go(3'd4, top2);
        wait_done("j_full_top", 0);

        go(3'd7, '0);
        @(posedge clk);
        #1 check("none_done_lat2", 64'(done), 1);
        check("none_count", 64'(cand_count), 0);
        @(posedge clk);
        #1 check("none_done_pulse", 64'(done), 0);

        cand_ready = 0;
        push_rot(0, 2, 2, 1);
        go(3'd1, '0);
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 64'(cand_valid), 1);
            check("bp_hold_x", 64'(cand_x), 0);
            check("bp_hold_row", 64'(cand_row), 18);
            check_board("bp_hold_board", cand_board, box(0, 18, 2, 2));
            @(negedge clk);
        end
        @(posedge clk);
        #1 cand_ready = 1;
        wait_done("bp", 9);

        d0 = n_done;
        go(3'd1, '0);
        repeat (3) @(posedge clk);
        #1 abort = 1;
        @(posedge clk);
        #1 abort = 0;
        check("abort_busy", 64'(busy), 0);
        check("abort_valid", 64'(cand_valid), 0);
        repeat (40) @(posedge clk);
        #1 check("abort_no_done", 64'(n_done), 64'(d0));
        push_rot(0, 2, 2, 1);
        go(3'd1, '0);
        wait_done("after_abort", 9);
        check("after_abort_done_once", 64'(n_done), 64'(d0 + 1));

        cand_ready = 0;
        d0 = n_done;
        go(3'd1, '0);
        wait_valid("rst_emit_valid");
        #2 reset = 1;
        #1 check("rst_emit_busy", 64'(busy), 0);
        check("rst_emit_valid", 64'(cand_valid), 0);
        check("rst_emit_count", 64'(cand_count), 0);
        check_board("rst_emit_board", cand_board, '0);
        @(posedge clk);
        #1 reset = 0;
        check("rst_emit_no_done", 64'(n_done), 64'(d0));
        cand_ready = 1;
        push_rot(0, 2, 2, 1);
        go(3'd1, '0);
        wait_done("after_reset", 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
